// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between the fetcher (I) and the LSQ (D).
// D has priority; a saturating starvation counter forces an I grant after STARVE_LIMIT losses.
module mem_port_arbiter #(
    parameter int unsigned width        = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_read,
    input  logic               i_write,
    input  logic [width/8-1:0] i_byte_enable,
    input  logic [width-1:0]   i_address,
    input  logic [width-1:0]   i_wdata,
    output logic               i_resp,
    output logic [width-1:0]   i_rdata,

    input  logic               d_read,
    input  logic               d_write,
    input  logic [width/8-1:0] d_byte_enable,
    input  logic [width-1:0]   d_address,
    input  logic [width-1:0]   d_wdata,
    output logic               d_resp,
    output logic [width-1:0]   d_rdata,

    output logic               mem_read,
    output logic               mem_write,
    output logic [width/8-1:0] mem_byte_enable,
    output logic [width-1:0]   mem_address,
    output logic [width-1:0]   mem_wdata,
    input  logic               mem_resp,
    input  logic [width-1:0]   mem_rdata,

    output logic               busy_i,
    output logic               busy_d
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    starve_q, starve_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [width/8-1:0] be_q, be_d;
    logic [width-1:0]   addr_q, addr_d;
    logic [width-1:0]   wdata_q, wdata_d;

    logic req_i, req_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        read_d   = read_q;
        write_d  = write_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_resp   = 1'b0;
        d_resp   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_i && (!req_d || starve_q >= Limit)) begin
                    state_d  = StIBusy;
                    starve_d = '0;
                    read_d   = i_read;
                    write_d  = i_write;
                    be_d     = i_byte_enable;
                    addr_d   = i_address;
                    wdata_d  = i_wdata;
                end else if (req_d) begin
                    state_d = StDBusy;
                    read_d  = d_read;
                    write_d = d_write;
                    be_d    = d_byte_enable;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    if (req_i && starve_q != Limit) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StIBusy: begin
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StDBusy: begin
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            read_q   <= read_d;
            write_q  <= write_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Read data is only meaningful alongside the matching resp.
    assign i_rdata         = mem_rdata;
    assign d_rdata         = mem_rdata;
    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign busy_i          = (state_q == StIBusy);
    assign busy_d          = (state_q == StDBusy);

endmodule
